clk_gate_ctrl: RTL and testbench

Idle-detection controller that generates the enable for the clock_gating cell in front of a compute unit such as a PE array or vector unit. It watches the unit's busy flag and incoming request valid. After a programmable run of idle cycles it drops the enable; on new work it re-enables the clock and holds off requests (ready low) for a fixed wake window. Saturating statistics counters report gating events and gated cycles to the CSR block.

---
 rtl/clk_gate_ctrl_if.sv | 27 ++
 rtl/clk_gate_ctrl.sv | 176 +++++++++++++++++
 tb/tb_clk_gate_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_gate_ctrl_if.sv
// Handshake and gating signals between the idle-detection controller and
// the upstream requester / gated compute unit.
interface clk_gate_ctrl_if;
    logic req_valid;
    logic unit_busy;
    logic req_ready;
    logic clk_en;
    logic gated;

    // Upstream requester / unit side: drives activity, observes gating.
    modport master (
        output req_valid,
        output unit_busy,
        input  req_ready,
        input  clk_en,
        input  gated
    );

    // Controller side.
    modport slave (
        input  req_valid,
        input  unit_busy,
        output req_ready,
        output clk_en,
        output gated
    );
endinterface

// File: rtl/clk_gate_ctrl.sv
// Idle-detection clock-gate controller. Counts idle cycles of a compute unit,
// drops the clock-gate enable after a programmable threshold, and on new work
// re-enables the clock while holding off requests for a fixed wake window.
// Saturating counters report gate entries and cycles spent gated.
module clk_gate_ctrl #(
    parameter int unsigned IDLE_CNT_W  = 8,
    parameter int unsigned WAKE_CYCLES = 2,
    parameter int unsigned STAT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_gate_en,
    input  logic [IDLE_CNT_W-1:0] cfg_idle_thresh,
    input  logic                  force_on,
    input  logic                  stat_clr,
    clk_gate_ctrl_if.slave        bus,
    output logic [STAT_W-1:0]     stat_gate_events,
    output logic [STAT_W-1:0]     stat_gated_cycles
);

    // Wake counter only needs to reach WAKE_CYCLES-1.
    localparam int unsigned WakeCntW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [WakeCntW-1:0] WakeLast = WakeCntW'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {
        StOn    = 2'd0,
        StCount = 2'd1,
        StOff   = 2'd2,
        StWake  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [WakeCntW-1:0]   wake_cnt_q, wake_cnt_d;
    logic                  clk_en_q, clk_en_d;
    logic                  req_ready_q, req_ready_d;
    logic                  gated_q, gated_d;
    logic [STAT_W-1:0]     events_q, events_d;
    logic [STAT_W-1:0]     cycles_q, cycles_d;

    logic                  wake_cond;
    logic                  idle;
    logic [IDLE_CNT_W-1:0] thr;
    logic                  event_inc;
    logic                  cycle_inc;

    // Activity detection and effective threshold (a zero threshold acts as 1).
    always_comb begin
        wake_cond = bus.req_valid | bus.unit_busy | force_on | ~cfg_gate_en;
        idle      = ~wake_cond;
        thr       = (cfg_idle_thresh == '0) ? IDLE_CNT_W'(1) : cfg_idle_thresh;
    end

    // Next-state logic for the gating FSM and its counters.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        unique case (state_q)
            StOn: begin
                if (idle) begin
                    state_d    = StCount;
                    idle_cnt_d = IDLE_CNT_W'(1);
                end
            end
            StCount: begin
                // req_valid is part of wake_cond, so ready never drops under a pending request.
                if (wake_cond) begin
                    state_d    = StOn;
                    idle_cnt_d = '0;
                end else if (idle_cnt_q >= thr) begin
                    state_d    = StOff;
                    idle_cnt_d = '0;
                end else if (idle_cnt_q != '1) begin
                    idle_cnt_d = idle_cnt_q + IDLE_CNT_W'(1);
                end
            end
            StOff: begin
                if (wake_cond) begin
                    state_d    = StWake;
                    wake_cnt_d = '0;
                end
            end
            StWake: begin
                // Runs to completion regardless of wake_cond; covers the gate cell's enable flop.
                if (wake_cnt_q == WakeLast) begin
                    state_d    = StOn;
                    wake_cnt_d = '0;
                end else begin
                    wake_cnt_d = wake_cnt_q + WakeCntW'(1);
                end
            end
            default: begin
                state_d    = StOn;
                idle_cnt_d = '0;
                wake_cnt_d = '0;
            end
        endcase
    end

    // Output decode from the next state so outputs are registered yet aligned with the state.
    always_comb begin
        clk_en_d    = 1'b1;
        req_ready_d = 1'b1;
        gated_d     = 1'b0;
        unique case (state_d)
            StOn, StCount: begin
                clk_en_d    = 1'b1;
                req_ready_d = 1'b1;
            end
            StOff: begin
                clk_en_d    = 1'b0;
                req_ready_d = 1'b0;
                gated_d     = 1'b1;
            end
            StWake: begin
                clk_en_d    = 1'b1;
                req_ready_d = 1'b0;
            end
            default: begin
                clk_en_d    = 1'b1;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // Saturating statistics; a clear takes priority over a same-cycle increment.
    always_comb begin
        event_inc = (state_d == StOff) && (state_q != StOff);
        cycle_inc = (state_d == StOff);

        events_d = events_q;
        if (stat_clr) begin
            events_d = '0;
        end else if (event_inc && (events_q != '1)) begin
            events_d = events_q + STAT_W'(1);
        end

        cycles_d = cycles_q;
        if (stat_clr) begin
            cycles_d = '0;
        end else if (cycle_inc && (cycles_q != '1)) begin
            cycles_d = cycles_q + STAT_W'(1);
        end
    end

    // State, counter and output registers; reset leaves the clock running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StOn;
            idle_cnt_q  <= '0;
            wake_cnt_q  <= '0;
            clk_en_q    <= 1'b1;
            req_ready_q <= 1'b1;
            gated_q     <= 1'b0;
            events_q    <= '0;
            cycles_q    <= '0;
        end else begin
            state_q     <= state_d;
            idle_cnt_q  <= idle_cnt_d;
            wake_cnt_q  <= wake_cnt_d;
            clk_en_q    <= clk_en_d;
            req_ready_q <= req_ready_d;
            gated_q     <= gated_d;
            events_q    <= events_d;
            cycles_q    <= cycles_d;
        end
    end

    assign bus.clk_en        = clk_en_q;
    assign bus.req_ready     = req_ready_q;
    assign bus.gated         = gated_q;
    assign stat_gate_events  = events_q;
    assign stat_gated_cycles = cycles_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: a default-width instance and a STAT_W=4 instance
// share stimulus; a cycle table plus directed multi-cycle sequences.
module tb_clk_gate_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_gate_en;
    logic [7:0] cfg_idle_thresh;
    logic       force_on;
    logic       stat_clr;
    logic [15:0] ev_w, cyc_w;
    logic [3:0]  ev_s, cyc_s;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_ev  = 0;
    int exp_cyc = 0;

    clk_gate_ctrl_if bus ();
    clk_gate_ctrl_if bus_s ();

    clk_gate_ctrl #(.IDLE_CNT_W(8), .WAKE_CYCLES(2), .STAT_W(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .cfg_gate_en       (cfg_gate_en),
        .cfg_idle_thresh   (cfg_idle_thresh),
        .force_on          (force_on),
        .stat_clr          (stat_clr),
        .bus               (bus),
        .stat_gate_events  (ev_w),
        .stat_gated_cycles (cyc_w)
    );

    clk_gate_ctrl #(.IDLE_CNT_W(8), .WAKE_CYCLES(2), .STAT_W(4)) dut_s (
        .clk               (clk),
        .rst               (rst),
        .cfg_gate_en       (cfg_gate_en),
        .cfg_idle_thresh   (cfg_idle_thresh),
        .force_on          (force_on),
        .stat_clr          (stat_clr),
        .bus               (bus_s),
        .stat_gate_events  (ev_s),
        .stat_gated_cycles (cyc_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic        busy;
        logic        fon;
        logic        gen;
        logic [7:0]  thr;
        logic        clr;
        logic        ce;
        logic        rdy;
        logic        g;
        logic [15:0] ev;
        logic [15:0] cyc;
    } vec_t;

    vec_t tbl[28];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rv, input logic busy, input logic fon, input logic gen,
                         input logic [7:0] thr, input logic clr);
        bus.req_valid   = rv;
        bus_s.req_valid = rv;
        bus.unit_busy   = busy;
        bus_s.unit_busy = busy;
        force_on        = fon;
        cfg_gate_en     = gen;
        cfg_idle_thresh = thr;
        stat_clr        = clr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stats(input string nm);
        chk({nm, "_ev"}, 32'(ev_w), 32'(exp_ev));
        chk({nm, "_cyc"}, 32'(cyc_w), 32'(exp_cyc));
        chk({nm, "_ev_s"}, 32'(ev_s), 32'((exp_ev > 15) ? 15 : exp_ev));
        chk({nm, "_cyc_s"}, 32'(cyc_s), 32'((exp_cyc > 15) ? 15 : exp_cyc));
    endtask

    // From ON, go idle and count edges until clk_en drops (bounded).
    task automatic gate_latency(input logic [7:0] thr, input int exp_lat);
        int lat;
        lat = 0;
        drive(1'b0, 1'b0, 1'b0, 1'b1, thr, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            lat++;
            if (bus.clk_en === 1'b0) break;
        end
        chk($sformatf("gate_lat_thr%0d", thr), 32'(lat), 32'(exp_lat));
        chk("gated_flag", 32'(bus.gated), 32'd1);
        exp_ev++;
        exp_cyc++;
    endtask

    // From OFF, hold a request until accepted; ready must follow the wake window.
    task automatic wake_seq();
        drive(1'b1, 1'b0, 1'b0, 1'b1, cfg_idle_thresh, 1'b0);
        step();
        chk("wake_ce_w1", 32'(bus.clk_en), 32'd1);
        chk("wake_rdy_w1", 32'(bus.req_ready), 32'd0);
        step();
        chk("wake_rdy_w2", 32'(bus.req_ready), 32'd0);
        step();
        chk("wake_rdy_w3", 32'(bus.req_ready), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b1, cfg_idle_thresh, 1'b0);
        step();
    endtask

    initial begin
        //           rv busy fon gen thr clr  ce rdy g  ev cyc
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 16'd1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 16'd2};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 16'd3};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 16'd3};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 16'd3};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1, 16'd3};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1, 16'd3};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1, 16'd3};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1, 16'd3};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1, 16'd3};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd4, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1, 16'd3};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1, 16'd3};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1, 16'd3};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1, 16'd3};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1, 16'd3};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 16'd4};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd4, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2, 16'd4};
        tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2, 16'd4};
        tbl[22] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2, 16'd4};
        tbl[23] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2, 16'd4};
        tbl[24] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd3, 16'd5};
        tbl[25] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3, 16'd5};
        tbl[26] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3, 16'd5};
        tbl[27] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd3, 16'd5};

        // Reset state.
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 1'b0);
        step();
        step();
        chk("rst_clk_en", 32'(bus.clk_en), 32'd1);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_gated", 32'(bus.gated), 32'd0);
        chk_stats("rst");
        rst = 1'b0;

        // Cycle-by-cycle table: gate, wake, busy interrupt, gate_en wake, thresh 0.
        for (int i = 0; i < 28; i++) begin
            drive(tbl[i].rv, tbl[i].busy, tbl[i].fon, tbl[i].gen, tbl[i].thr, tbl[i].clr);
            step();
            chk($sformatf("v%0d_clk_en", i), 32'(bus.clk_en), 32'(tbl[i].ce));
            chk($sformatf("v%0d_req_ready", i), 32'(bus.req_ready), 32'(tbl[i].rdy));
            chk($sformatf("v%0d_gated", i), 32'(bus.gated), 32'(tbl[i].g));
            chk($sformatf("v%0d_ev", i), 32'(ev_w), 32'(tbl[i].ev));
            chk($sformatf("v%0d_cyc", i), 32'(cyc_w), 32'(tbl[i].cyc));
            chk($sformatf("v%0d_ev_s", i), 32'(ev_s), 32'(tbl[i].ev[3:0]));
        end

        // Overrides keep clocks on through long idle periods.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 1'b0);
        for (int i = 0; i < 100; i++) begin
            step();
            chk("force_on_clk_en", 32'(bus.clk_en), 32'd1);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0);
        for (int i = 0; i < 100; i++) begin
            step();
            chk("gate_dis_clk_en", 32'(bus.clk_en), 32'd1);
        end

        // Clear stats while held busy in ON.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 1'b1);
        step();
        exp_ev  = 0;
        exp_cyc = 0;
        chk_stats("clr_on");

        // Gating latency for several thresholds.
        gate_latency(8'd4, 5);
        wake_seq();
        gate_latency(8'd1, 2);
        wake_seq();
        gate_latency(8'd0, 2);
        wake_seq();
        chk_stats("lat_runs");

        // 20 more gate events: narrow counters saturate.
        for (int n = 0; n < 20; n++) begin
            gate_latency(8'd1, 2);
            wake_seq();
        end
        chk_stats("sat_events");

        // Long OFF dwell saturates narrow cycle counter.
        gate_latency(8'd1, 2);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            exp_cyc++;
        end
        chk_stats("sat_cycles");

        // Clear coincident with an increment in OFF wins.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1);
        step();
        exp_ev  = 0;
        exp_cyc = 0;
        chk_stats("clr_vs_inc");
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0);
        step();
        exp_cyc = 1;
        chk_stats("after_clr");

        // Asynchronous reset in the middle of WAKE.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0);
        step();
        chk("pre_rst_rdy", 32'(bus.req_ready), 32'd0);
        chk("pre_rst_ce", 32'(bus.clk_en), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_clk_en", 32'(bus.clk_en), 32'd1);
        chk("arst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("arst_gated", 32'(bus.gated), 32'd0);
        exp_ev  = 0;
        exp_cyc = 0;
        chk_stats("arst");
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'd4, 1'b0);
        step();
        rst = 1'b0;
        step();
        gate_latency(8'd4, 5);
        chk_stats("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
